// File: rtl/serial_word_xform.sv
// serial_word_xform
// ------------------------------------------------------------------------
// Bit-serial, LSB-first word transformer. Each WIDTH-bit word is passed,
// one's-complemented, two's-complemented or incremented according to the
// mode sampled on the word's first accepted bit. A single carry bit ripples
// through the word one bit per cycle. The output is registered, so every
// accepted bit appears one cycle later.
//
// Parameters
//   WIDTH     bits per word (2..64)
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, clears all state
//   sync_clr  synchronous word abort; framing restarts at bit 0
//   in_valid  in_bit is valid this cycle
//   in_bit    serial data bit, LSB first
//   mode      00 pass, 01 one's complement, 10 two's complement, 11 increment
//   out_valid one-cycle pulse per accepted bit
//   out_bit   transformed serial bit
//   out_last  out_bit is the MSB of its word
//   ovf       signed overflow of the completed word, meaningful with out_last
module serial_word_xform #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync_clr,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic [1:0] mode,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    output logic       ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] bit_idx;
    logic [CW-1:0] cnt_next;
    logic [1:0]    mode_q;
    logic [1:0]    mode_eff;
    logic          carry;
    logic          c_cur;
    logic          x;
    logic          inv;
    logic          word_start;
    logic          is_last;

    // Per-bit datapath. A sync_clr coinciding with a valid bit makes that bit
    // the first bit of a fresh word, so it behaves exactly like cnt == 0:
    // the mode is taken live from the port and the carry is reseeded.
    always_comb begin
        word_start = sync_clr || (cnt == '0);
        bit_idx    = sync_clr ? '0 : cnt;
        mode_eff   = word_start ? mode : mode_q;
        inv        = (mode_eff == 2'b01) || (mode_eff == 2'b10);
        // Modes 10 and 11 both add one, so the seed is simply mode bit 1.
        c_cur      = word_start ? mode_eff[1] : carry;
        x          = in_bit ^ inv;
        is_last    = (bit_idx == LAST_IDX);
        cnt_next   = is_last ? '0 : bit_idx + CW'(1);
    end

    // State and output registers. Only accepted bits advance the word;
    // a lone sync_clr just rewinds the framing and drops the partial word.
    // Overflow is carry-in XOR carry-out at the MSB, which reduces to c & ~x.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            carry     <= 1'b0;
            mode_q    <= 2'b00;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bit  <= x ^ c_cur;
                out_last <= is_last;
                ovf      <= is_last & c_cur & ~x;
                carry    <= c_cur & x;
                mode_q   <= mode_eff;
                cnt      <= cnt_next;
            end else if (sync_clr) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: doc/serial_word_xform.md
# serial_word_xform

Parametrised bit-serial word transformer, LSB-first. It generalises the two-state serial two's-complement FSM to framed `WIDTH`-bit words with four modes: pass, one's complement, two's complement and increment. It supports a valid qualifier, word framing, a per-word signed-overflow flag and a registered output. It sits in the serial datapath between a bit-serial source and any bit-serial consumer that needs negated, inverted or incremented operands.

## Interface
- `WIDTH`, default 8: bits per word, LSB first; legal range 2..64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sync_clr`  in  1  synchronous word abort; restarts framing at bit 0.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit.
- `mode`  in  2  transform select: 00 pass, 01 one's complement, 10 two's complement, 11 increment.
- `out_valid`  out  1  `out_bit` is valid.
- `out_bit`  out  1  transformed serial bit.
- `out_last`  out  1  `out_bit` is the MSB of its word.
- `ovf`  out  1  signed overflow of the completed word; valid only with `out_last`.

## Operation
- Bit counter `cnt`, width clog2(`WIDTH`), counts accepted bits (`in_valid`=1) from 0 to `WIDTH`-1, then wraps to 0.
- Cycles with `in_valid`=0 change no state (gaps allowed anywhere in a word).
- Mode latch:
  - `mode` is sampled only on the accepted bit with `cnt`=0 and held for the rest of the word.
  - Changes to `mode` mid-word are ignored.
- Per-word control, from the latched mode:
  - `inv` = 1 for modes 01 and 10.
  - Carry seed = 1 for modes 10 and 11, 0 otherwise.
- Per accepted bit, with c = carry state (seeded value on bit 0) and x = `in_bit` ^ `inv`:
  - `out_bit` = x ^ c.
  - c_next = c & x.
- Mode 10 reproduces the classic FSM: state "no 1 seen" passes bits, state "1 seen" inverts them.
- Overflow, on the MSB (`cnt`=`WIDTH`-1) only: `ovf` = c & ~x, i.e. carry-in to MSB XOR carry-out of MSB.
  - Mode 10 flags only 100..0.
  - Mode 11 flags only 011..1.
  - Modes 00 and 01 never flag.
- Carry is reseeded at every word start; nothing carries across words.
- Mode 11 carry state machine: SEED (c=1) → PROP (c stays 1 while x=1) → DONE (c=0 after the first x=0) → SEED at word end.
- `sync_clr`:
  - Forces `cnt`=0 and drops the partial word; no `out_last` is issued for it.
  - If asserted together with `in_valid`, that bit is accepted as bit 0 of a new word, with `mode` sampled on it.
- Reset mid-word: all state is cleared; the next accepted bit is bit 0.

## Timing
- Reset values: `out_valid`=0, `out_bit`=0, `out_last`=0, `ovf`=0, `cnt`=0, carry=0, mode latch=00.
- Latency is one cycle: an accepted bit in cycle n yields `out_valid`=1 with `out_bit`, `out_last` and `ovf` registered in cycle n+1.
- `out_valid` is a one-cycle pulse per accepted bit. With `in_valid`=0 in cycle n, `out_valid`=0 in cycle n+1.
- `out_bit`, `out_last` and `ovf` hold their last values while `out_valid`=0. They are don't-care for the consumer.
- `ovf` is 0 whenever `out_last`=0 in a valid cycle.
- Throughput is one bit per cycle, sustained, with no back-pressure. Words may be issued back-to-back (bit `WIDTH`-1 followed by bit 0 of the next word).
- `sync_clr` takes effect at the clock edge where it is sampled. The output pipeline register still delivers the bit accepted in the previous cycle.

## Test plan
- `WIDTH`=8, mode 10, word 0x05 back-to-back → output word 0xFB; `out_last` on 8th output only; `ovf`=0.
- Mode 10, 0x80 → 0x80, `ovf`=1. Mode 10, 0x00 → 0x00, `ovf`=0.
- Mode 11, 0x7F → 0x80, `ovf`=1. Mode 11, 0xFF → 0x00, `ovf`=0. Mode 01, 0x3C → 0xC3, `ovf`=0. Mode 00, 0xA5 → 0xA5.
- Mode 10, 0x06 with random `in_valid` gaps, and `mode` toggled to 11 after bit 2 → 0xFA. `out_valid` count = 8, each one cycle after its accepted input.
- Assert `reset` asynchronously after 3 bits of a mode 10 word → all outputs 0 immediately. Then 0x01 → 0xFF.
- Pulse `sync_clr` with `in_valid` after 5 bits of a word → no `out_last` for the aborted word. The coincident bit starts a new word; 0x02 in mode 10 → 0xFE.
